// File: rtl/cache_mem_arbiter_if.sv
// Cache-side and memory-side signals of the I/D line-fill arbiter.
interface cache_mem_arbiter_if #(
    parameter int BEAT_W = 64
);
    logic              i_pmem_read;
    logic [31:0]       i_pmem_address;
    logic [255:0]      i_pmem_rdata;
    logic              i_pmem_resp;
    logic              d_pmem_read;
    logic              d_pmem_write;
    logic [31:0]       d_pmem_address;
    logic [255:0]      d_pmem_wdata;
    logic [255:0]      d_pmem_rdata;
    logic              d_pmem_resp;
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_address;
    logic [BEAT_W-1:0] mem_burst_o;
    logic [BEAT_W-1:0] mem_burst_i;
    logic              mem_resp;

    modport slave (
        input  i_pmem_read, i_pmem_address,
        input  d_pmem_read, d_pmem_write,
        input  d_pmem_address, d_pmem_wdata,
        input  mem_burst_i, mem_resp,
        output i_pmem_rdata, i_pmem_resp,
        output d_pmem_rdata, d_pmem_resp,
        output mem_read, mem_write,
        output mem_address, mem_burst_o
    );

    modport master (
        output i_pmem_read, i_pmem_address,
        output d_pmem_read, d_pmem_write,
        output d_pmem_address, d_pmem_wdata,
        output mem_burst_i, mem_resp,
        input  i_pmem_rdata, i_pmem_resp,
        input  d_pmem_rdata, d_pmem_resp,
        input  mem_read, mem_write,
        input  mem_address, mem_burst_o
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Arbitrates I-cache fills and D-cache fills/writebacks onto one
// burst memory port; D-side has fixed priority.
module cache_mem_arbiter #(
    parameter int BEAT_W = 64,
    parameter int BEATS  = 4
) (
    input logic                clk,
    input logic                rst,
    cache_mem_arbiter_if.slave bus
);
    localparam int LINE_W = BEAT_W * BEATS;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            state;
    state_t            state_n;
    logic [CNT_W-1:0]  cnt;
    logic              owner_d;
    logic [31:0]       addr;
    logic [LINE_W-1:0] wdata;
    logic [LINE_W-1:0] line;
    logic              d_req;
    logic              last_beat;

    assign d_req     = bus.d_pmem_read || bus.d_pmem_write;
    assign last_beat = bus.mem_resp && (int'(cnt) == BEATS - 1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            owner_d <= 1'b0;
            addr    <= '0;
            wdata   <= '0;
            line    <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (d_req) begin
                        owner_d <= 1'b1;
                        addr    <= bus.d_pmem_address;
                        wdata   <= bus.d_pmem_wdata;
                    end else if (bus.i_pmem_read) begin
                        owner_d <= 1'b0;
                        addr    <= bus.i_pmem_address;
                    end
                end
                READ: begin
                    if (bus.mem_resp) begin
                        line[BEAT_W*int'(cnt) +: BEAT_W] <= bus.mem_burst_i;
                        cnt <= last_beat ? '0 : cnt + 1'b1;
                    end
                end
                WRITE: begin
                    if (bus.mem_resp)
                        cnt <= last_beat ? '0 : cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // A simultaneous read+write from D is a writeback; the fill follows later.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (bus.d_pmem_write)
                    state_n = WRITE;
                else if (bus.d_pmem_read || bus.i_pmem_read)
                    state_n = READ;
            end
            READ, WRITE: begin
                if (last_beat)
                    state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are forced low while reset is held, even before the reset edge.
    always_comb begin
        bus.mem_read     = 1'b0;
        bus.mem_write    = 1'b0;
        bus.mem_address  = '0;
        bus.mem_burst_o  = '0;
        bus.i_pmem_resp  = 1'b0;
        bus.d_pmem_resp  = 1'b0;
        bus.i_pmem_rdata = '0;
        bus.d_pmem_rdata = '0;
        if (rst) begin
            bus.mem_read     = (state == READ);
            bus.mem_write    = (state == WRITE);
            bus.i_pmem_resp  = (state == DONE) && !owner_d;
            bus.d_pmem_resp  = (state == DONE) && owner_d;
            bus.i_pmem_rdata = line;
            bus.d_pmem_rdata = line;
            if (state == READ || state == WRITE)
                bus.mem_address = addr & ~32'h1F;
            if (state == WRITE)
                bus.mem_burst_o = wdata[BEAT_W*int'(cnt) +: BEAT_W];
        end
    end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Randomised scoreboard bench for cache_mem_arbiter with a line-level
// memory reference model and a stalling burst memory responder.
module tb_cache_mem_arbiter;
    localparam int BW = 64;
    localparam int NB = 4;

    typedef struct {
        bit           wr;
        bit [31:0]    addr;
        logic [255:0] line;
        int           t;
    } xact_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   nchk = 0;
    int   nfail = 0;
    int   nresp = 0;
    int   last_resp = -100;
    int   max_stall = 0;
    bit   noise = 1'b0;

    xact_t        exp_i[$];
    xact_t        exp_d[$];
    xact_t        exp_bus[$];
    int           stall_q[$];
    logic [255:0] ref_mem [bit [31:0]];

    int           beat = 0;
    int           stall_left = 0;
    int           bstall = 0;
    logic [255:0] cur;

    bit [31:0]    a1;
    bit [31:0]    a2;
    logic [255:0] w1;
    logic [255:0] l38;
    logic [255:0] wd39;
    int           kind;
    int           n;
    int           seen;

    cache_mem_arbiter_if #(.BEAT_W(BW)) bus ();

    cache_mem_arbiter #(.BEAT_W(BW), .BEATS(NB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [255:0] got, logic [255:0] want);
        nchk++;
        if (got !== want) begin
            nfail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    function automatic logic [255:0] rnd_line();
        logic [255:0] v;
        for (int j = 0; j < 8; j++) v[32*j +: 32] = $urandom;
        return v;
    endfunction

    // Reference model: a line-addressed memory, bursts served in order.
    task automatic model(bit d, bit wr, bit [31:0] a, logic [255:0] wd);
        xact_t   e;
        bit [31:0] al;
        al = a & ~32'h1F;
        if (!ref_mem.exists(al)) ref_mem[al] = rnd_line();
        if (wr) ref_mem[al] = wd;
        e.wr = wr;
        e.addr = al;
        e.line = ref_mem[al];
        e.t = cyc;
        exp_bus.push_back(e);
        if (d) exp_d.push_back(e);
        else exp_i.push_back(e);
    endtask

    // Memory responder with random per-beat stalls and stray mem_resp noise.
    always @(negedge clk) begin
        bus.mem_resp = 1'b0;
        if (!rst) begin
            beat = 0;
            stall_left = 0;
            bstall = 0;
        end else if (bus.mem_read || bus.mem_write) begin
            check("one_strobe", {bus.mem_read, bus.mem_write} == 2'b11, 0);
            if (stall_left > 0) begin
                stall_left--;
                bstall++;
            end else if (exp_bus.size() == 0) begin
                check("unexpected_burst", 1, 0);
            end else begin
                cur = exp_bus[0].line;
                check("burst_addr", bus.mem_address, exp_bus[0].addr);
                check("burst_op", bus.mem_write, exp_bus[0].wr);
                if (exp_bus[0].wr)
                    check("wbeat", bus.mem_burst_o, cur[beat*BW +: BW]);
                else
                    bus.mem_burst_i = cur[beat*BW +: BW];
                bus.mem_resp = 1'b1;
                beat++;
                stall_left = $urandom_range(max_stall, 0);
                if (beat == NB) begin
                    beat = 0;
                    stall_q.push_back(bstall);
                    bstall = 0;
                    void'(exp_bus.pop_front());
                end
            end
        end else if (noise && $urandom_range(3, 0) == 0) begin
            bus.mem_resp = 1'b1;
            bus.mem_burst_i = {$urandom, $urandom};
        end
    end

    task automatic got_resp(bit d);
        xact_t e;
        int    s;
        int    start;
        nresp++;
        if ((d && exp_d.size() == 0) || (!d && exp_i.size() == 0)) begin
            check(d ? "d_unexpected_resp" : "i_unexpected_resp", 1, 0);
            return;
        end
        if (d) e = exp_d.pop_front();
        else e = exp_i.pop_front();
        s = (stall_q.size() > 0) ? stall_q.pop_front() : 0;
        start = (e.t > last_resp + 1) ? e.t : last_resp + 1;
        if (!e.wr) begin
            if (d) check("d_rdata", bus.d_pmem_rdata, e.line);
            else check("i_rdata", bus.i_pmem_rdata, e.line);
        end
        check("resp_cycle", cyc, start + 5 + s);
        check("done_strobes", {bus.mem_read, bus.mem_write}, 0);
        last_resp = cyc;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (bus.d_pmem_resp) got_resp(1'b1);
            if (bus.i_pmem_resp) got_resp(1'b0);
        end
    end

    task automatic release_req(bit d);
        if (d) begin
            bus.d_pmem_read = 1'b0;
            bus.d_pmem_write = 1'b0;
        end else begin
            bus.i_pmem_read = 1'b0;
        end
    endtask

    task automatic drive(bit d, bit wr, bit [31:0] a, logic [255:0] wd,
                         int drop, bit both);
        int k;
        k = 0;
        if (d) begin
            bus.d_pmem_address = a;
            bus.d_pmem_wdata = wd;
            bus.d_pmem_read = !wr || both;
            bus.d_pmem_write = wr;
        end else begin
            bus.i_pmem_address = a;
            bus.i_pmem_read = 1'b1;
        end
        while (!(d ? bus.d_pmem_resp : bus.i_pmem_resp) && k < 300) begin
            @(posedge clk);
            #1;
            k++;
            if (k == drop) release_req(d);
        end
        if (k >= 300) check(d ? "d_timeout" : "i_timeout", 0, 1);
        @(posedge clk);
        #1;
        release_req(d);
    endtask

    task automatic xact(bit d, bit wr, bit [31:0] a, logic [255:0] wd,
                        int drop, bit both);
        model(d, wr, a, wd);
        drive(d, wr, a, wd, drop, both);
    endtask

    task automatic pair(bit dwr, bit both, bit [31:0] da, logic [255:0] dw,
                        bit [31:0] ia);
        model(1'b1, dwr, da, dw);
        model(1'b0, 1'b0, ia, '0);
        fork
            drive(1'b1, dwr, da, dw, 0, both);
            drive(1'b0, 1'b0, ia, '0, 0, 1'b0);
        join
    endtask

    initial begin
        bus.i_pmem_read = 1'b0;
        bus.i_pmem_address = '0;
        bus.d_pmem_read = 1'b0;
        bus.d_pmem_write = 1'b0;
        bus.d_pmem_address = '0;
        bus.d_pmem_wdata = '0;
        bus.mem_burst_i = '0;
        bus.mem_resp = 1'b0;
        #1;
        check("inrst_strobes", {bus.mem_read, bus.mem_write}, 0);
        check("inrst_resp", {bus.i_pmem_resp, bus.d_pmem_resp}, 0);
        check("inrst_rdata", bus.i_pmem_rdata, 0);
        check("inrst_addr", bus.mem_address, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        check("reset_line_i", bus.i_pmem_rdata, 0);
        check("reset_line_d", bus.d_pmem_rdata, 0);
        check("reset_strobes", {bus.mem_read, bus.mem_write}, 0);

        l38 = {64'h4444444444444444, 64'h3333333333333333,
               64'h2222222222222222, 64'h1111111111111111};
        ref_mem[32'h0000_1220] = l38;
        xact(1'b0, 1'b0, 32'h0000_1234, '0, 0, 1'b0);
        check("i_line_fixed", bus.i_pmem_rdata, l38);

        wd39 = {64'hDEAD_0000_0000_0003, 64'hDEAD_0000_0000_0002,
                64'hDEAD_0000_0000_0001, 64'hDEAD_0000_0000_0000};
        xact(1'b1, 1'b1, 32'h8000_0040, wd39, 0, 1'b0);
        check("line_held_after_wb", bus.d_pmem_rdata, l38);
        xact(1'b0, 1'b0, 32'h8000_0040, '0, 0, 1'b0);
        check("readback_wb", bus.i_pmem_rdata, wd39);

        pair(1'b0, 1'b0, 32'h0000_2010, '0, 32'h0000_3008);
        pair(1'b1, 1'b1, 32'h0000_3000, rnd_line(), 32'h0000_3004);
        xact(1'b1, 1'b0, 32'h0000_4000, '0, 2, 1'b0);

        max_stall = 3;
        noise = 1'b1;
        for (int k = 0; k < 40; k++) begin
            a1 = 32'h0001_0000 | ($urandom_range(7, 0) << 5) | $urandom_range(31, 0);
            a2 = 32'h0001_0000 | ($urandom_range(7, 0) << 5) | $urandom_range(31, 0);
            w1 = rnd_line();
            kind = $urandom_range(5, 0);
            case (kind)
                0: xact(1'b0, 1'b0, a1, '0, 0, 1'b0);
                1: xact(1'b1, 1'b0, a1, '0, 0, 1'b0);
                2: xact(1'b1, 1'b1, a1, w1, 0, 1'b0);
                3: pair($urandom_range(1, 0) == 1, 1'b0, a1, w1, a2);
                4: xact(1'b1, 1'b1, a1, w1, 0, 1'b1);
                default: xact($urandom_range(1, 0) == 1, 1'b0, a1, '0, 2, 1'b0);
            endcase
        end

        max_stall = 0;
        noise = 1'b0;
        model(1'b0, 1'b0, 32'h0000_5000, '0);
        bus.i_pmem_address = 32'h0000_5000;
        bus.i_pmem_read = 1'b1;
        n = 0;
        while (beat != 2 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reached_beat2", beat, 2);
        rst = 1'b0;
        bus.i_pmem_read = 1'b0;
        exp_i.delete();
        exp_d.delete();
        exp_bus.delete();
        stall_q.delete();
        seen = nresp;
        #1 check("rst_mid_mem_read", bus.mem_read, 0);
        @(posedge clk);
        #1 check("post_rst_mem_read", bus.mem_read, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        check("post_rst_idle", {bus.mem_read, bus.mem_write}, 0);
        check("post_rst_line", bus.i_pmem_rdata, 0);
        repeat (8) @(posedge clk);
        #1 check("no_resp_after_abort", nresp - seen, 0);
        xact(1'b0, 1'b0, 32'h0000_5000, '0, 0, 1'b0);
        check("after_reset_line", bus.i_pmem_rdata, ref_mem[32'h0000_5000]);
        check("queues_drained", exp_bus.size() + exp_i.size() + exp_d.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule

// File: doc/cache_mem_arbiter.md
CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 SHALL have parameter BEAT_W, default 64: physical memory burst beat width in bits.
REQ-002 SHALL have parameter BEATS, default 4: beats per 256-bit line (BEATS*BEAT_W == 256).
REQ-003 SHALL have port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous and active-low (0 = reset).
REQ-005 SHALL have port i_pmem_read  input  1: I-cache line fill request.
REQ-006 SHALL have port i_pmem_address  input  32: I-cache line address.
REQ-007 SHALL have port i_pmem_rdata  output  256: I-cache fill line.
REQ-008 SHALL have port i_pmem_resp  output  1: I-cache completion pulse.
REQ-009 SHALL have ports d_pmem_read / d_pmem_write  input  1 each: D-cache fill / writeback request.
REQ-010 SHALL have port d_pmem_address  input  32: D-cache line address.
REQ-011 SHALL have port d_pmem_wdata  input  256: D-cache writeback line.
REQ-012 SHALL have port d_pmem_rdata  output  256: D-cache fill line.
REQ-013 SHALL have port d_pmem_resp  output  1: D-cache completion pulse.
REQ-014 SHALL have ports mem_read / mem_write  output  1 each: physical memory burst read / write strobe.
REQ-015 SHALL have port mem_address  output  32: line-aligned burst address.
REQ-016 SHALL have port mem_burst_o  output  BEAT_W: write beat data.
REQ-017 SHALL have port mem_burst_i  input  BEAT_W: read beat data.
REQ-018 SHALL have port mem_resp  input  1: high one cycle per accepted/returned beat.

Function
REQ-019 SHALL implement FSM states IDLE, READ, WRITE, DONE.
REQ-020 IDLE: if d_pmem_read or d_pmem_write, SHALL latch owner=D, op, address, and d_pmem_wdata, then go to READ (read) or WRITE (write); else if i_pmem_read, SHALL latch owner=I and address, then go to READ; else stay IDLE.
REQ-021 D-side SHALL have fixed priority over I-side when both request in the same IDLE cycle.
REQ-022 d_pmem_read and d_pmem_write both high SHALL be treated as write (writeback precedes fill).
REQ-023 mem_address SHALL equal the latched address with bits [4:0] forced to 0 while in READ or WRITE.
REQ-024 READ: mem_read=1; each cycle with mem_resp=1 SHALL store mem_burst_i into line bits [BEAT_W*cnt +: BEAT_W] and increment 2-bit beat counter cnt.
REQ-025 WRITE: mem_write=1; mem_burst_o SHALL equal latched wdata[BEAT_W*cnt +: BEAT_W]; each mem_resp cycle SHALL increment cnt.
REQ-026 On the mem_resp cycle with cnt==BEATS-1, SHALL go to DONE next cycle and wrap cnt to 0.
REQ-027 mem_resp=0 SHALL hold state, cnt, and strobes; no timeout.
REQ-028 DONE: SHALL assert owner's *_pmem_resp for exactly one cycle, other side's resp 0, mem_read=mem_write=0, then go to IDLE.
REQ-029 i_pmem_rdata and d_pmem_rdata SHALL both drive the line buffer, valid in DONE and held until the next READ overwrites it.
REQ-030 Minimum latency SHALL be 6 cycles from request in IDLE to resp (1 IDLE + 4 beats + 1 DONE).
REQ-031 A request deasserted mid-burst SHALL NOT abort the burst; resp SHALL still pulse in DONE.
REQ-032 Requesters SHALL hold requests until resp; the arbiter SHALL NOT re-accept a request in the DONE cycle.
REQ-033 mem_resp in IDLE or DONE SHALL be ignored.
REQ-034 mem_read and mem_write SHALL never both be 1.

Reset
REQ-035 rst=0 at a clock edge SHALL force IDLE, cnt=0, owner=I, line buffer=0, and latched address/wdata=0.
REQ-036 While in reset, SHALL drive all outputs to 0.
REQ-037 Reset mid-burst SHALL abort; strobes SHALL be 0 the cycle after the reset edge; no resp for the aborted transaction.

Verification
REQ-038 I-side read at 0x0000_1234, beats 0x11..,0x22..,0x33..,0x44.. -> mem_address=0x0000_1220; i_pmem_rdata={0x44..,0x33..,0x22..,0x11..}; i_pmem_resp pulses once, 6 cycles after request.
REQ-039 D-side write of 0xDEAD... line to 0x8000_0040 -> mem_write for 4 beats; mem_burst_o = wdata[63:0], [127:64], [191:128], [255:192] in order; single d_pmem_resp pulse.
REQ-040 i_pmem_read and d_pmem_read asserted in the same cycle -> D served first with d_pmem_resp; I served immediately after; both rdata correct; no overlap of strobes.
REQ-041 Random 0-3 idle cycles between mem_resp beats -> data placement is unchanged and resp is delayed by exactly the inserted stall count.
REQ-042 rst=0 after 2 read beats -> mem_read=0 next cycle and no resp; a new request after reset completes normally with cnt starting at 0.
